msp430_trace_ctrl: RTL
======================

// Module: msp430_trace_ctrl
// PURPOSE
//  Instruction-trace capture controller beside the core debug monitor. On each decode it
//  samples {irq_detect, pc, ir} into a circular buffer, runs an arm/trigger/post-trigger
//  sequence, then freezes and lets a host drain the buffer oldest-first. Pure observer.
// PARAMETERS
//  DEPTH  16  buffer entries; power of 2, >=4. Localparam AW = $clog2(DEPTH).
// PORTS
//  mclk        in   1      main system clock; single clock domain
//  puc_rst     in   1      asynchronous, active-high reset
//  decode      in   1      core decode strobe; one capture opportunity per cycle
//  pc          in   16     program counter of decoded instruction
//  ir          in   16     instruction register of decoded instruction
//  irq_detect  in   1      decode is an interrupt entry
//  arm         in   1      pulse: clear buffer, start capture
//  disarm      in   1      pulse: stop capture, go IDLE
//  trig_en     in   1      enable PC-match trigger
//  trig_pc     in   16     trigger PC value
//  post_cnt    in   AW     instructions captured after the trigger instruction
//  rd_req      in   1      pop oldest entry; honoured only in IDLE/DONE with level!=0
//  rd_valid    out  1      rd_data valid (1-cycle pulse)
//  rd_data     out  33     {irq, pc[15:0], ir[15:0]}
//  level       out  AW+1   entries held, 0..DEPTH
//  state       out  2      0 IDLE, 1 ARMED, 2 POST, 3 DONE
//  trig_hit    out  1      1-cycle pulse, cycle after the trigger capture
//  done        out  1      high while state==DONE
// BEHAVIOUR
//  Reset: state IDLE, wr_ptr/rd_ptr/level 0, post counter 0, rd_valid 0, rd_data 0,
//   trig_hit 0, done 0. Buffer RAM not reset.
//  Capture: when decode=1 in ARMED/POST, entry written at wr_ptr on that edge;
//   wr_ptr+1 mod DEPTH. level+1 saturating at DEPTH; when full, rd_ptr+1 too
//   (oldest overwritten).
//  IDLE: no capture. arm -> ARMED; clears wr_ptr, rd_ptr, level.
//  ARMED: capture. Trigger = decode & trig_en & (pc==trig_pc); trigger instruction is
//   captured. trig_hit=1 next cycle. post_cnt==0 -> DONE, else load counter -> POST.
//   trig_en=0: captures indefinitely (circular) until disarm/arm.
//  POST: each decode captures and decrements counter; capture that takes it to 0 -> DONE
//   on the same edge. Exactly post_cnt instructions follow the trigger entry.
//  DONE: capture frozen; done=1. arm -> ARMED (restart, buffer cleared).
//  Read (IDLE/DONE only): rd_req & level!=0 -> next edge rd_data=mem[rd_ptr],
//   rd_valid=1, rd_ptr+1 mod DEPTH, level-1. Latency 1 cycle; back-to-back every cycle.
//   level==0 or ARMED/POST: rd_req ignored, rd_valid 0, rd_data holds.
//  disarm (any state) -> IDLE next edge; pointers/level kept, buffer remains readable.
//  Priority: disarm > arm > trigger/capture. arm in ARMED/POST restarts capture;
//   decode on the same edge as arm is not captured.
//  Reset mid-operation: asynchronous return to reset values; buffer contents invalid.
// STRUCTURE
//  msp430_trace_pkg: trace_state_e {IDLE,ARMED,POST,DONE}, trace_entry_t {irq,pc,ir},
//   TRACE_W=33.
//  Sub-module msp430_trace_ram: DEPTH x 33 register array, 1 sync write port, 1 sync read
//   port. Controller owns FSM, pointers, level, post counter.
// TESTING
//  1. Assert puc_rst mid-capture -> state=0, level=0, rd_valid=0, done=0, immediately.
//  2. arm; trig_en=1, trig_pc=16'hF004, post_cnt=2; decodes pc F000,F002,F004,F006,F008
//     -> trig_hit after 3rd, DONE after 5th, level=5; 5 rd_req -> pcs F000..F008 in
//     order; 6th rd_req -> rd_valid=0.
//  3. DEPTH=16, trig_en=1, post_cnt=0, 20 decodes with trigger on 20th -> level=16,
//     first read = 5th captured entry, last read = trigger entry.
//  4. disarm during POST after 1 of 3 post captures -> IDLE, further decodes ignored,
//     level unchanged, entries readable.
//  5. arm and disarm same cycle from IDLE -> stays IDLE, level unchanged.
//  6. rd_req held during ARMED with level=3 -> rd_valid stays 0, level keeps counting.

Source files
------------

// File: rtl/msp430_trace_pkg.sv
// Shared types for the instruction-trace capture block: FSM encoding and the captured entry layout.
package msp430_trace_pkg;

    localparam int TRACE_W = 33;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        POST  = 2'd2,
        DONE  = 2'd3
    } trace_state_e;

    typedef struct packed {
        logic        irq;
        logic [15:0] pc;
        logic [15:0] ir;
    } trace_entry_t;

endpackage

// File: rtl/msp430_trace_ram.sv
// Trace storage: DEPTH x TRACE_W register array with one sync write and one sync read port.
// Read data appears one cycle after re and holds otherwise; array contents are not reset.
module msp430_trace_ram
    import msp430_trace_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  trace_entry_t  wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output trace_entry_t  rdata
);

    trace_entry_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/msp430_trace_ctrl.sv
// Instruction-trace controller: circular capture on decode, arm/trigger/post-trigger, then host drain.
// Capture lands on the decode edge; reads return one cycle after rd_req, back-to-back, only in IDLE/DONE.
module msp430_trace_ctrl
    import msp430_trace_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic               mclk,
    input  logic               puc_rst,
    input  logic               decode,
    input  logic [15:0]        pc,
    input  logic [15:0]        ir,
    input  logic               irq_detect,
    input  logic               arm,
    input  logic               disarm,
    input  logic               trig_en,
    input  logic [15:0]        trig_pc,
    input  logic [AW-1:0]      post_cnt,
    input  logic               rd_req,
    output logic               rd_valid,
    output logic [TRACE_W-1:0] rd_data,
    output logic [AW:0]        level,
    output logic [1:0]         state,
    output logic               trig_hit,
    output logic               done
);

    localparam int LW = AW + 1;
    localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);
    localparam logic [LW-1:0] LVL_ONE  = LW'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    trace_state_e  state_q, state_d;
    logic [AW-1:0] wr_ptr_q, rd_ptr_q, post_q;
    logic [LW-1:0] level_q;
    logic          trig_hit_q, rd_valid_q;
    logic          capturing, capture, trigger, rd_en, arm_go;
    trace_entry_t  wr_entry, rd_entry;

    // disarm outranks arm, and either one suppresses a same-edge capture
    assign arm_go    = arm & ~disarm;
    assign capturing = (state_q == ARMED) || (state_q == POST);
    assign capture   = decode & capturing & ~arm & ~disarm;
    assign trigger   = capture & (state_q == ARMED) & trig_en & (pc == trig_pc);
    assign rd_en     = rd_req & ~arm_go & (level_q != '0) &
                       ((state_q == IDLE) || (state_q == DONE));

    assign wr_entry = '{irq: irq_detect, pc: pc, ir: ir};

    always_ff @(posedge mclk or posedge puc_rst) begin
        if (puc_rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (disarm) begin
            state_d = IDLE;
        end else if (arm) begin
            state_d = ARMED;
        end else begin
            case (state_q)
                ARMED: begin
                    if (trigger) begin
                        state_d = (post_cnt == '0) ? DONE : POST;
                    end
                end
                POST: begin
                    if (capture && (post_q == PTR_ONE)) begin
                        state_d = DONE;
                    end
                end
                default: state_d = state_q;
            endcase
        end
    end

    always_comb begin
        state    = state_q;
        done     = (state_q == DONE);
        trig_hit = trig_hit_q;
        rd_valid = rd_valid_q;
        level    = level_q;
    end

    always_ff @(posedge mclk or posedge puc_rst) begin
        if (puc_rst) begin
            post_q     <= '0;
            trig_hit_q <= 1'b0;
            rd_valid_q <= 1'b0;
        end else begin
            trig_hit_q <= trigger;
            rd_valid_q <= rd_en;
            if (trigger) begin
                post_q <= post_cnt;
            end else if (capture && (state_q == POST)) begin
                post_q <= post_q - PTR_ONE;
            end
        end
    end

    // When full, a new capture pushes the read pointer so the oldest entry is overwritten
    always_ff @(posedge mclk or posedge puc_rst) begin
        if (puc_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else if (arm_go) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else if (capture) begin
            wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (level_q == LVL_FULL) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end else begin
                level_q <= level_q + LVL_ONE;
            end
        end else if (rd_en) begin
            rd_ptr_q <= rd_ptr_q + PTR_ONE;
            level_q  <= level_q - LVL_ONE;
        end
    end

    msp430_trace_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk   (mclk),
        .rst   (puc_rst),
        .we    (capture),
        .waddr (wr_ptr_q),
        .wdata (wr_entry),
        .re    (rd_en),
        .raddr (rd_ptr_q),
        .rdata (rd_entry)
    );

    assign rd_data = rd_entry;

endmodule
